inst_fetch_queue: RTL

Instruction fetch unit and instruction queue feeding the decode stage. Maintains the fetch PC, issues word fetches to the memory controller with at most one request outstanding, and buffers returned instructions with their PCs in a circular FIFO. Decode consumes the head entry via `Get_Inst`. A ROB redirect (`clear`) flushes the queue and restarts fetch at the jump target.

---
 rtl/inst_fetch_queue.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit plus circular instruction queue feeding decode.
// Keeps the fetch PC and issues word fetches with at most one request outstanding.
// Returned instructions are buffered with their PCs until decode pops them.
// A ROB redirect (clear) flushes the queue and restarts fetch at jump_pc.
module inst_fetch_queue #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic [31:0] jump_pc,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_inst,
    input  logic        Get_Inst,
    output logic [31:0] IQ_Inst,
    output logic [31:0] IQ_pc,
    output logic        IQ_en,
    output logic        IQ_isempty,
    output logic        IQ_isfull
);

    localparam int unsigned   DEPTH      = 1 << DEPTH_LOG2;
    localparam int unsigned   CW         = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Fetch FSM: DROP means a request is outstanding but its data belongs to a
    // path that has since been flushed.
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDrop = 2'd2;

    logic [31:0]           mem_inst_q [DEPTH];
    logic [31:0]           mem_pc_q   [DEPTH];

    logic [1:0]            state_q,      state_d;
    logic [31:0]           fetch_pc_q,   fetch_pc_d;
    logic                  fetch_req_q,  fetch_req_d;
    logic [31:0]           fetch_addr_q, fetch_addr_d;
    logic [DEPTH_LOG2-1:0] head_q,       head_d;
    logic [DEPTH_LOG2-1:0] tail_q,       tail_d;
    logic [CW-1:0]         count_q,      count_d;

    logic                  do_pop;
    logic                  do_push;
    logic [CW-1:0]         count_after;
    logic                  has_space;
    logic                  has_space_after;
    logic                  is_empty;

    // Qualify push/pop; clear overrides both
    always_comb begin
        is_empty        = (count_q == '0);
        do_pop          = Get_Inst && !is_empty && !clear;
        do_push         = (state_q == StWait) && fetch_ack && !clear;
        // Space is reserved at issue, so count_q < DEPTH whenever do_push is set
        count_after     = count_q + CW'(do_push) - CW'(do_pop);
        has_space       = (count_q < FULL_COUNT);
        has_space_after = (count_after < FULL_COUNT);
    end

    // Next-state logic for the fetch FSM and queue pointers
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        fetch_req_d  = fetch_req_q;
        fetch_addr_d = fetch_addr_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;

        if (clear) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = jump_pc;
            // An outstanding request is never withdrawn; its data is dropped instead
            case (state_q)
                StWait: begin
                    if (fetch_ack) begin
                        state_d     = StIdle;
                        fetch_req_d = 1'b0;
                    end else begin
                        state_d = StDrop;
                    end
                end
                StDrop: begin
                    if (fetch_ack) begin
                        state_d     = StIdle;
                        fetch_req_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    fetch_req_d = 1'b0;
                end
            endcase
        end else begin
            if (do_pop) begin
                head_d = head_q + DEPTH_LOG2'(1);
            end
            if (do_push) begin
                tail_d = tail_q + DEPTH_LOG2'(1);
            end
            count_d = count_after;

            case (state_q)
                StIdle: begin
                    if (has_space) begin
                        state_d      = StWait;
                        fetch_req_d  = 1'b1;
                        fetch_addr_d = fetch_pc_q;
                    end
                end
                StWait: begin
                    if (fetch_ack) begin
                        fetch_pc_d = fetch_addr_q + 32'd4;
                        if (has_space_after) begin
                            // Back-to-back: next request issued in the ack cycle
                            fetch_addr_d = fetch_addr_q + 32'd4;
                        end else begin
                            fetch_req_d = 1'b0;
                            state_d     = StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (fetch_ack) begin
                        fetch_req_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    fetch_req_d = 1'b0;
                end
            endcase
        end
    end

    // Control state: synchronous active-low reset, frozen while rdy_in is low
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            fetch_req_q  <= 1'b0;
            fetch_addr_q <= 32'h0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            fetch_req_q  <= fetch_req_d;
            fetch_addr_q <= fetch_addr_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    // Queue storage: write the acked word with the address it was fetched from
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && do_push) begin
            mem_inst_q[tail_q] <= fetch_inst;
            mem_pc_q[tail_q]   <= fetch_addr_q;
        end
    end

    // Head outputs and flags, from registered state only
    always_comb begin
        fetch_req  = fetch_req_q;
        fetch_addr = fetch_addr_q;
        IQ_isempty = is_empty;
        IQ_isfull  = (count_q == FULL_COUNT);
        IQ_en      = !is_empty;
        IQ_Inst    = is_empty ? 32'h0 : mem_inst_q[head_q];
        IQ_pc      = is_empty ? 32'h0 : mem_pc_q[head_q];
    end

    // Invariants on queue occupancy and the request handshake
    assert property (@(posedge clk_in) disable iff (!rst_in)
        count_q <= FULL_COUNT)
        else $error("queue count exceeds depth");

    assert property (@(posedge clk_in) disable iff (!rst_in)
        (tail_q - head_q) == count_q[DEPTH_LOG2-1:0])
        else $error("queue pointers disagree with count");

    assert property (@(posedge clk_in) disable iff (!rst_in)
        (rdy_in && do_push) |-> has_space)
        else $error("push into a full queue");

    assert property (@(posedge clk_in) disable iff (!rst_in)
        (fetch_req_q && !fetch_ack) |=> (fetch_req_q && $stable(fetch_addr_q)))
        else $error("fetch request withdrawn or address changed before ack");

endmodule
